up_sample: RTL and testbench

Linear-interpolating upsampler: the transmit-side counterpart of `down_sample`. It accepts a signed sample stream at a low rate and emits L = 1, 2, 4 or 8 output samples per input. The outputs step linearly from the previous input to the current one. It sits between a sample source (file reader, decimated DSP path) and a full-rate consumer, with valid/ready handshakes on both sides.

---
 rtl/up_sample_pkg.sv | 30 +++
 rtl/up_sample_interp.sv | 33 +++
 rtl/up_sample.sv | 114 +++++++++++
 tb/tb_up_sample.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/up_sample_pkg.sv
// Shared definitions for the linear-interpolating upsampler: factor codes,
// FSM states and helpers converting a factor code to its shift and length.
package up_sample_pkg;

    localparam logic [1:0] FACTOR_L1 = 2'd0;
    localparam logic [1:0] FACTOR_L2 = 2'd1;
    localparam logic [1:0] FACTOR_L4 = 2'd2;
    localparam logic [1:0] FACTOR_L8 = 2'd3;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // The factor code is already log2 of the interpolation length.
    function automatic logic [1:0] factor_shift(input logic [1:0] code);
        return code;
    endfunction

    function automatic logic [3:0] factor_len(input logic [1:0] code);
        case (code)
            FACTOR_L1: return 4'd1;
            FACTOR_L2: return 4'd2;
            FACTOR_L4: return 4'd4;
            FACTOR_L8: return 4'd8;
            default:   return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/up_sample_interp.sv
// Combinational interpolation point: y = prev + floor(diff * j / 2^s).
module up_sample_interp #(
    parameter int data_width = 16
) (
    input  logic [data_width-1:0] prev,
    input  logic [data_width:0]   diff,
    input  logic [3:0]            j,
    input  logic [1:0]            s,
    output logic [data_width-1:0] y
);

    logic signed [data_width+3:0] diff_ext;
    logic signed [data_width+3:0] j_ext;
    logic signed [data_width+3:0] product;
    logic signed [data_width+3:0] scaled;
    logic        [data_width:0]   sum;
    logic                         unused_bits;

    assign diff_ext = {{3{diff[data_width]}}, diff};
    assign j_ext    = {{data_width{1'b0}}, j};
    assign product  = diff_ext * j_ext;

    // Arithmetic shift floors toward minus infinity; the result magnitude never
    // exceeds |diff|, so the upper bits are pure sign extension.
    assign scaled = product >>> s;

    // The interpolated point lies between prev and cur, so truncation is exact.
    assign sum = {prev[data_width-1], prev} + scaled[data_width:0];
    assign y   = sum[data_width-1:0];

    assign unused_bits = ^{scaled[data_width+3:data_width+1], sum[data_width]};

endmodule

// File: rtl/up_sample.sv
// Linear-interpolating upsampler: emits L = 1, 2, 4 or 8 samples per input,
// stepping from the previous input to the current one, valid/ready on both sides.
module up_sample
    import up_sample_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [data_width-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_factor,
    output logic [data_width-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    state_t                state, state_next;
    logic [data_width-1:0] prev, prev_next;
    logic [data_width-1:0] cur, cur_next;
    logic [data_width:0]   diff, diff_next;
    logic [1:0]            s, s_next;
    logic [3:0]            j, j_next;
    logic [data_width-1:0] data_next;

    logic                  last;
    logic                  accept;
    logic                  step;
    logic [data_width-1:0] base;
    logic [data_width:0]   new_diff;

    logic [data_width-1:0] interp_prev;
    logic [data_width:0]   interp_diff;
    logic [3:0]            interp_j;
    logic [1:0]            interp_s;
    logic [data_width-1:0] interp_y;

    assign o_valid = (state == EMIT);
    assign last    = (j == factor_len(s));
    assign o_ready = i_rst && ((state == IDLE) || (i_ready && last));
    assign accept  = i_valid && o_ready;
    assign step    = o_valid && i_ready;

    // An accept during the final handshake must see cur already promoted to prev.
    assign base     = o_valid ? cur : prev;
    assign new_diff = {i_data[data_width-1], i_data} - {base[data_width-1], base};

    up_sample_interp #(
        .data_width(data_width)
    ) u_interp (
        .prev(interp_prev),
        .diff(interp_diff),
        .j   (interp_j),
        .s   (interp_s),
        .y   (interp_y)
    );

    always_comb begin
        state_next  = state;
        prev_next   = prev;
        cur_next    = cur;
        diff_next   = diff;
        s_next      = s;
        j_next      = j;
        data_next   = o_data;
        interp_prev = prev;
        interp_diff = diff;
        interp_j    = j + 4'd1;
        interp_s    = s;

        if (step && last) begin
            prev_next  = cur;
            state_next = IDLE;
        end

        if (accept) begin
            interp_prev = base;
            interp_diff = new_diff;
            interp_j    = 4'd1;
            interp_s    = factor_shift(i_factor);
            cur_next    = i_data;
            diff_next   = new_diff;
            s_next      = factor_shift(i_factor);
            j_next      = 4'd1;
            data_next   = interp_y;
            state_next  = EMIT;
        end else if (step && !last) begin
            j_next    = j + 4'd1;
            data_next = interp_y;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            prev   <= '0;
            cur    <= '0;
            diff   <= '0;
            s      <= '0;
            j      <= 4'd1;
            o_data <= '0;
        end else begin
            state  <= state_next;
            prev   <= prev_next;
            cur    <= cur_next;
            diff   <= diff_next;
            s      <= s_next;
            j      <= j_next;
            o_data <= data_next;
        end
    end

endmodule

// File: tb/tb_up_sample.sv
// Directed self-checking bench for up_sample with hand-computed expected samples.
module tb_up_sample;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_factor;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;

    int tests_run;
    int tests_failed;

    up_sample #(
        .data_width(16)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_factor(i_factor),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int d, input logic [1:0] f, input logic r);
        i_valid  = v;
        i_data   = d[15:0];
        i_factor = f;
        i_ready  = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input int exp_data,
                               input logic exp_ready);
        int got_data;
        got_data = int'($signed(o_data));
        tests_run++;
        assert (o_valid === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL %s o_valid got %b expected %b", tag, o_valid, exp_valid);
        end
        tests_run++;
        assert (got_data === exp_data) else begin
            tests_failed++;
            $error("[TB] FAIL %s o_data got %0d expected %0d", tag, got_data, exp_data);
        end
        tests_run++;
        assert (o_ready === exp_ready) else begin
            tests_failed++;
            $error("[TB] FAIL %s o_ready got %b expected %b", tag, o_ready, exp_ready);
        end
    endtask

    task automatic doReset();
        i_rst = 1'b0;
        #1;
        checkOutput("reset_held", 1'b0, 0, 1'b0);
        tick();
        i_rst = 1'b1;
        applyStimulus(1'b0, 0, 2'd0, 1'b1);
        checkOutput("reset_release", 1'b0, 0, 1'b1);
    endtask

    initial begin
        int k;
        int cycles;
        logic r;
        tests_run    = 0;
        tests_failed = 0;

        // Reset held with random inputs
        i_rst    = 1'b0;
        i_valid  = 1'($urandom);
        i_data   = 16'($urandom);
        i_factor = 2'($urandom);
        i_ready  = 1'($urandom);
        tick();
        checkOutput("rst_a", 1'b0, 0, 1'b0);
        i_valid  = 1'b1;
        i_data   = 16'($urandom);
        tick();
        checkOutput("rst_b", 1'b0, 0, 1'b0);
        i_rst = 1'b1;
        applyStimulus(1'b0, 0, 2'd0, 1'b1);
        checkOutput("rst_release", 1'b0, 0, 1'b1);

        // L2 ramp: 100 then 0
        applyStimulus(1'b1, 100, 2'd1, 1'b1);
        checkOutput("l2_idle", 1'b0, 0, 1'b1);
        tick();
        applyStimulus(1'b1, 0, 2'd1, 1'b1);
        checkOutput("l2_y1", 1'b1, 50, 1'b0);
        tick();
        checkOutput("l2_y2", 1'b1, 100, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 2'd1, 1'b1);
        checkOutput("l2_y3", 1'b1, 50, 1'b0);
        tick();
        checkOutput("l2_y4", 1'b1, 0, 1'b1);
        tick();
        checkOutput("l2_done", 1'b0, 0, 1'b1);

        // L4 floor, positive step from 0 to 3
        applyStimulus(1'b1, 3, 2'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 2'd2, 1'b1);
        checkOutput("l4p_y1", 1'b1, 0, 1'b0);
        tick();
        checkOutput("l4p_y2", 1'b1, 1, 1'b0);
        tick();
        checkOutput("l4p_y3", 1'b1, 2, 1'b0);
        tick();
        checkOutput("l4p_y4", 1'b1, 3, 1'b1);
        tick();
        checkOutput("l4p_done", 1'b0, 3, 1'b1);

        // L4 floor, negative step from 0 to -3
        doReset();
        applyStimulus(1'b1, -3, 2'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 2'd2, 1'b1);
        checkOutput("l4n_y1", 1'b1, -1, 1'b0);
        tick();
        checkOutput("l4n_y2", 1'b1, -2, 1'b0);
        tick();
        checkOutput("l4n_y3", 1'b1, -3, 1'b0);
        tick();
        checkOutput("l4n_y4", 1'b1, -3, 1'b1);
        tick();

        // L8 with backpressure pattern 1,0,0 repeating
        doReset();
        applyStimulus(1'b1, 80, 2'd3, 1'b1);
        tick();
        k      = 1;
        cycles = 0;
        while (k <= 8 && cycles < 40) begin
            r = (cycles % 3 == 0);
            applyStimulus(1'b0, 0, 2'd3, r);
            checkOutput("l8_bp", 1'b1, 10 * k, (k == 8) && r);
            if (r) k++;
            cycles++;
            tick();
        end
        tests_run++;
        assert (k == 9) else begin
            tests_failed++;
            $error("[TB] FAIL l8_bp_count got %0d expected 9", k - 1);
        end
        applyStimulus(1'b0, 0, 2'd3, 1'b1);
        checkOutput("l8_bp_done", 1'b0, 80, 1'b1);

        // L1 bypass streaming 1..4
        applyStimulus(1'b1, 1, 2'd0, 1'b1);
        tick();
        for (int n = 2; n <= 4; n++) begin
            applyStimulus(1'b1, n, 2'd0, 1'b1);
            checkOutput("l1_stream", 1'b1, n - 1, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 0, 2'd0, 1'b1);
        checkOutput("l1_last", 1'b1, 4, 1'b1);
        tick();
        checkOutput("l1_done", 1'b0, 4, 1'b1);

        // Factor changed mid-L8 burst: 4 -> 12 stays 8 long, then bypass 100
        applyStimulus(1'b1, 12, 2'd3, 1'b1);
        tick();
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(1'b1, 100, 2'd0, 1'b1);
            checkOutput("l8_factor_chg", 1'b1, 4 + n, n == 8);
            tick();
        end
        applyStimulus(1'b0, 0, 2'd0, 1'b1);
        checkOutput("after_chg", 1'b1, 100, 1'b1);
        tick();

        // Extremes: 32767 then -32768 at L2
        applyStimulus(1'b1, 32767, 2'd0, 1'b1);
        tick();
        applyStimulus(1'b1, -32768, 2'd1, 1'b1);
        checkOutput("ext_max", 1'b1, 32767, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 2'd1, 1'b1);
        checkOutput("ext_y1", 1'b1, -1, 1'b0);
        tick();
        checkOutput("ext_y2", 1'b1, -32768, 1'b1);
        tick();

        // Reset during the first output of an L8 burst
        applyStimulus(1'b1, 50, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 2'd3, 1'b1);
        i_rst = 1'b0;
        #1;
        checkOutput("rst_mid", 1'b0, 0, 1'b0);
        tick();
        i_rst = 1'b1;
        applyStimulus(1'b1, 8, 2'd3, 1'b1);
        checkOutput("rst_mid_rel", 1'b0, 0, 1'b1);
        tick();
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(1'b0, 0, 2'd3, 1'b1);
            checkOutput("post_rst_l8", 1'b1, n, n == 8);
            tick();
        end
        checkOutput("post_rst_done", 1'b0, 8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
